instruction_fetch_unit: RTL and testbench

- Producer end of the Instruction interface: fetches 32-bit MIPS words from instruction memory and presents them to the decode/control stage one at a time.
- Consumes the control stage's Branch/Jump/Jr/Jal decisions to redirect the PC.
- Sits between the instruction ROM and the decode stage of the single-issue datapath.

---
 rtl/instruction_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Single-issue instruction fetch: one outstanding ROM request, one word presented to decode at a time.
// Optional IFU_PERF_COUNT_EN adds FetchCount/FlushCount performance counters.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          ALIGN_JR = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemRValid,
    input  logic [31:0] ImemRData,
    output logic [31:0] Instruction,
    output logic [31:0] IfPC,
    output logic [31:0] LinkAddr,
    output logic        IfValid,
    input  logic        IdReady,
    input  logic        Branch,
    input  logic        BranchTaken,
    input  logic        Jump,
    input  logic        Jr,
    input  logic        Jal,
    input  logic [31:0] JrTarget,
    input  logic        Flush,
    input  logic [31:0] FlushPC
`ifdef IFU_PERF_COUNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] FlushCount
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] instr, instr_n;
    logic [31:0] ifpc, ifpc_n;
    logic [31:0] addr_q, addr_q_n;
    logic        ifvalid, ifvalid_n;
    logic        pending, pending_n;
    logic        drop, drop_n;
    logic        accept;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] jr_pc;

    assign ImemAddr    = pc;
    assign Instruction = instr;
    assign IfPC        = ifpc;
    assign IfValid     = ifvalid;
    assign LinkAddr    = ifpc + 32'd4;

    assign jr_pc = ALIGN_JR ? {JrTarget[31:2], 2'b00} : JrTarget;

    // pc already holds IfPC+4 while in HOLD, so "no redirect" keeps it as is
    always_comb begin
        target   = pc;
        redirect = 1'b1;
        if (Jr)
            target = jr_pc;
        else if (Jump || Jal)
            target = {LinkAddr[31:28], instr[25:0], 2'b00};
        else if (Branch && BranchTaken)
            target = LinkAddr + {{14{instr[15]}}, instr[15:0], 2'b00};
        else
            redirect = 1'b0;
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        instr_n   = instr;
        ifpc_n    = ifpc;
        addr_q_n  = addr_q;
        ifvalid_n = ifvalid;
        pending_n = pending;
        drop_n    = drop;
        ImemReq   = 1'b0;
        accept    = 1'b0;
        if (Flush) begin
            pc_n      = FlushPC;
            ifvalid_n = 1'b0;
            pending_n = 1'b0;
            state_n   = ISSUE;
            // A response landing this cycle is simply not captured; only a
            // still-outstanding one has to be remembered and discarded later.
            drop_n    = (state == WAIT) && !ImemRValid;
        end else begin
            case (state)
                IDLE: state_n = ISSUE;
                ISSUE: begin
                    ImemReq   = 1'b1;
                    addr_q_n  = pc;
                    pc_n      = pc + 32'd4;
                    pending_n = 1'b1;
                    state_n   = WAIT;
                end
                WAIT: begin
                    if (ImemRValid) begin
                        pending_n = 1'b0;
                        if (drop) begin
                            drop_n  = 1'b0;
                            state_n = ISSUE;
                        end else begin
                            instr_n   = ImemRData;
                            ifpc_n    = addr_q;
                            ifvalid_n = 1'b1;
                            state_n   = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (IdReady) begin
                        accept    = 1'b1;
                        ifvalid_n = 1'b0;
                        pc_n      = target;
                        state_n   = ISSUE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            instr   <= 32'd0;
            ifpc    <= 32'd0;
            addr_q  <= 32'd0;
            ifvalid <= 1'b0;
            pending <= 1'b0;
            drop    <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            instr   <= instr_n;
            ifpc    <= ifpc_n;
            addr_q  <= addr_q_n;
            ifvalid <= ifvalid_n;
            pending <= pending_n;
            drop    <= drop_n;
        end
    end

`ifdef IFU_PERF_COUNT_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            FetchCount <= 32'd0;
            FlushCount <= 32'd0;
        end else begin
            if (accept)
                FetchCount <= FetchCount + 32'd1;
            if (Flush || (accept && redirect))
                FlushCount <= FlushCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: redirect vector table plus hand sequences
// for reset, stall, flush and async reset corner cases.
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemRValid = 1'b0;
    logic [31:0] ImemRData = 32'd0;
    logic [31:0] Instruction, IfPC, LinkAddr;
    logic        IfValid;
    logic        IdReady = 1'b0;
    logic        Branch = 1'b0, BranchTaken = 1'b0, Jump = 1'b0, Jr = 1'b0, Jal = 1'b0;
    logic [31:0] JrTarget = 32'd0;
    logic        Flush = 1'b0;
    logic [31:0] FlushPC = 32'd0;
`ifdef IFU_PERF_COUNT_EN
    logic [31:0] FetchCount, FlushCount;
`endif

    int nchk = 0;
    int nerr = 0;

    instruction_fetch_unit #(.RESET_PC(32'h0), .ALIGN_JR(1'b1)) dut (
        .Clk(Clk), .Reset(Reset),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemRValid(ImemRValid), .ImemRData(ImemRData),
        .Instruction(Instruction), .IfPC(IfPC), .LinkAddr(LinkAddr), .IfValid(IfValid),
        .IdReady(IdReady), .Branch(Branch), .BranchTaken(BranchTaken),
        .Jump(Jump), .Jr(Jr), .Jal(Jal), .JrTarget(JrTarget),
        .Flush(Flush), .FlushPC(FlushPC)
`ifdef IFU_PERF_COUNT_EN
        , .FetchCount(FetchCount), .FlushCount(FlushCount)
`endif
    );

    always #5 Clk = ~Clk;

    // beq at 0x100 (imm 0xFFFE), j at 0x1000_0000 (index 0x40), everything else address-tagged
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h1000_FFFE;
            32'h1000_0000: return 32'h0800_0040;
            default:       return a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    // ROM answers exactly one cycle after each request
    always_ff @(posedge Clk) begin
        ImemRValid <= ImemReq;
        ImemRData  <= ImemReq ? mem_word(ImemAddr) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] start;
        logic        br, tk, jmp, jr, jal;
        logic [31:0] jrt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{"beq_taken",   32'h0000_0100, 1, 1, 0, 0, 0, 32'h0, 32'h0000_00FC};
        vecs[1] = '{"beq_not",     32'h0000_0100, 1, 0, 0, 0, 0, 32'h0, 32'h0000_0104};
        vecs[2] = '{"j",           32'h1000_0000, 0, 0, 1, 0, 0, 32'h0, 32'h1000_0100};
        vecs[3] = '{"jr_over_j",   32'h1000_0000, 0, 0, 1, 1, 0, 32'h203, 32'h0000_0200};
        vecs[4] = '{"j_over_br",   32'h1000_0000, 1, 1, 1, 0, 0, 32'h0, 32'h1000_0100};
        vecs[5] = '{"pc_wrap",     32'hFFFF_FFFC, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0000};
        vecs[6] = '{"jal",         32'h0000_0100, 0, 0, 0, 0, 1, 32'h0, 32'h0003_FFF8};

        // reset state
        IdReady = 1'b1;
        step(); step();
        chk("rst_ifvalid", {31'd0, IfValid}, 32'd0);
        chk("rst_instr", Instruction, 32'd0);
        chk("rst_ifpc", IfPC, 32'd0);
        chk("rst_req", {31'd0, ImemReq}, 32'd0);

        // sequential stream, requests on cycles 1,4,7
        Reset = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            chk($sformatf("seq_req_c%0d", c), {31'd0, ImemReq}, {31'd0, (c % 3 == 1)});
            if (c % 3 == 1)
                chk($sformatf("seq_addr_c%0d", c), ImemAddr, 32'(4 * (c / 3)));
            chk($sformatf("seq_valid_c%0d", c), {31'd0, IfValid}, {31'd0, (c % 3 == 0)});
            if (c % 3 == 0) begin
                chk($sformatf("seq_ifpc_c%0d", c), IfPC, 32'(4 * (c / 3 - 1)));
                chk($sformatf("seq_instr_c%0d", c), Instruction, mem_word(32'(4 * (c / 3 - 1))));
                chk($sformatf("seq_link_c%0d", c), LinkAddr, 32'(4 * (c / 3)));
            end
        end

        // decode stall for 5 cycles while holding word at 0x8
        IdReady = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            chk("stall_valid", {31'd0, IfValid}, 32'd1);
            chk("stall_ifpc", IfPC, 32'h8);
            chk("stall_instr", Instruction, mem_word(32'h8));
            chk("stall_req", {31'd0, ImemReq}, 32'd0);
        end
        IdReady = 1'b1;
        step();
        IdReady = 1'b0;
        chk("release_req", {31'd0, ImemReq}, 32'd1);
        chk("release_addr", ImemAddr, 32'hC);

        // flush while the response is arriving
        step();
        Flush = 1'b1; FlushPC = 32'h80;
        step();
        chk("flushw_valid", {31'd0, IfValid}, 32'd0);
        Flush = 1'b0;
        #1;
        chk("flushw_req", {31'd0, ImemReq}, 32'd1);
        chk("flushw_addr", ImemAddr, 32'h80);

        // flush held high: reloads PC each cycle, no request
        Flush = 1'b1; FlushPC = 32'h200;
        #1;
        chk("flushh_req0", {31'd0, ImemReq}, 32'd0);
        for (int s = 0; s < 3; s++) begin
            step();
            chk("flushh_req", {31'd0, ImemReq}, 32'd0);
            chk("flushh_valid", {31'd0, IfValid}, 32'd0);
        end
        Flush = 1'b0;
        #1;
        chk("flushh_rel_req", {31'd0, ImemReq}, 32'd1);
        chk("flushh_rel_addr", ImemAddr, 32'h200);

        // async reset in the middle of HOLD
        step(); step();
        chk("hold_valid", {31'd0, IfValid}, 32'd1);
        chk("hold_ifpc", IfPC, 32'h200);
        #2 Reset = 1'b0;
        #1;
        chk("arst_valid", {31'd0, IfValid}, 32'd0);
        chk("arst_instr", Instruction, 32'd0);
        chk("arst_ifpc", IfPC, 32'd0);
        chk("arst_req", {31'd0, ImemReq}, 32'd0);
        chk("arst_pc", ImemAddr, 32'd0);
        step();
        Reset = 1'b1;

        // redirect vectors
        foreach (vecs[i]) begin
            int n;
            Flush = 1'b1; FlushPC = vecs[i].start;
            step();
            Flush = 1'b0;
            n = 0;
            while (!IfValid && n < 10) begin step(); n++; end
            chk({vecs[i].name, "_ifpc"}, IfPC, vecs[i].start);
            chk({vecs[i].name, "_instr"}, Instruction, mem_word(vecs[i].start));
            chk({vecs[i].name, "_link"}, LinkAddr, vecs[i].start + 32'd4);
            Branch = vecs[i].br; BranchTaken = vecs[i].tk; Jump = vecs[i].jmp;
            Jr = vecs[i].jr; Jal = vecs[i].jal; JrTarget = vecs[i].jrt;
            IdReady = 1'b1;
            step();
            {Branch, BranchTaken, Jump, Jr, Jal} = 5'b0;
            IdReady = 1'b0;
            n = 0;
            while (!ImemReq && n < 10) begin step(); n++; end
            chk({vecs[i].name, "_req"}, {31'd0, ImemReq}, 32'd1);
            chk({vecs[i].name, "_next"}, ImemAddr, vecs[i].exp);
        end

`ifdef IFU_PERF_COUNT_EN
        Reset = 1'b0;
        #1;
        chk("perf_rst_fetch", FetchCount, 32'd0);
        step();
        Reset = 1'b1; IdReady = 1'b1;
        for (int c = 0; c < 10; c++) step();
        chk("perf_fetch3", FetchCount, 32'd3);
        chk("perf_flush0", FlushCount, 32'd0);
        IdReady = 1'b0;
        step(); step();
        Branch = 1'b1; BranchTaken = 1'b1; IdReady = 1'b1;
        step();
        Branch = 1'b0; BranchTaken = 1'b0; IdReady = 1'b0;
        chk("perf_fetch4", FetchCount, 32'd4);
        chk("perf_flush1", FlushCount, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
